core_ctrl: RTL and testbench

Multi-cycle control FSM for the RV32I core datapath (pc, insmem, regfile, alu, datamem). Replaces the free-running, opcode-decoded write strobes with a sequenced FETCH/DECODE/EXEC/MEM/WB flow. Adds ready/req handshakes to instruction and data memory so either can have variable latency. Provides a retired-instruction counter and a sticky trap state.

---
 rtl/core_ctrl.sv | 143 ++++++++++++++
 tb/tb_core_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath with memory handshakes, timeout trap and retired counter
module core_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ins,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        br_eq,
  input  logic        br_lt,
  input  logic        br_ltu,
  output logic        imem_req,
  output logic        ir_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        pc_write,
  output logic [1:0]  pc_sel,
  output logic        regfile_write,
  output logic [1:0]  wb_sel,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [9:0]  alu_fn,
  output logic        halted,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] MEM    = 3'd4;
  localparam logic [2:0] WB     = 3'd5;
  localparam logic [2:0] TRAP   = 3'd6;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  logic [2:0]       state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       cause_nx;
  logic             inc, timeout, taken, legal, alu_en;
  logic [6:0]       op;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic             is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic             unused_ins;
  assign op         = ins[6:0];
  assign f3         = ins[14:12];
  assign f7         = ins[31:25];
  assign unused_ins = ^ins[24:15];
  assign is_r       = op == OP_R;
  assign is_i       = op == OP_I;
  assign is_ld      = op == OP_LD;
  assign is_st      = op == OP_ST;
  assign is_br      = op == OP_BR;
  assign is_jal     = op == OP_JAL;
  assign is_jalr    = op == OP_JALR;
  assign is_lui     = op == OP_LUI;
  assign is_auipc   = op == OP_AUIPC;
  // branch funct3 010/011 have no defined condition, so they are rejected at decode
  assign legal   = is_r | is_i | is_ld | is_st | (is_br & (f3[2:1] != 2'b01)) |
                   is_jal | is_jalr | is_lui | is_auipc;
  assign taken   = (f3[2] ? (f3[1] ? br_ltu : br_lt) : br_eq) ^ f3[0];
  assign timeout = (MEM_TIMEOUT != 0) && (cnt == CNT_W'(MEM_TIMEOUT - 1));
  // ALU controls stay stable through MEM/WB so an unregistered ALU result remains valid
  assign alu_en    = (state == EXEC) | (state == MEM) | (state == WB);
  assign alu_src_a = alu_en & is_auipc;
  assign alu_src_b = alu_en & (is_i | is_ld | is_st | is_jalr | is_auipc | is_lui);
  assign alu_fn    = !alu_en ? 10'd0 :
                     is_r    ? {f7, f3} :
                     is_i    ? ((f3 == 3'b101) ? {f7, f3} : {7'd0, f3}) : 10'd0;
  assign halted    = state == TRAP;
  always_comb begin
    state_nx      = state;
    cause_nx      = trap_cause;
    inc           = 1'b0;
    imem_req      = 1'b0;
    ir_write      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    pc_write      = 1'b0;
    pc_sel        = 2'd0;
    regfile_write = 1'b0;
    wb_sel        = 2'd0;
    case (state)
      IDLE: state_nx = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
        state_nx = imem_ready ? DECODE : timeout ? TRAP : FETCH;
        cause_nx = (!imem_ready && timeout) ? 2'd2 : trap_cause;
      end
      DECODE: begin
        state_nx = legal ? EXEC : TRAP;
        cause_nx = legal ? trap_cause : 2'd1;
      end
      EXEC: begin
        pc_write = is_br;
        pc_sel   = {1'b0, is_br & taken};
        inc      = is_br;
        state_nx = is_br ? FETCH : (is_ld | is_st) ? MEM : WB;
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_st;
        pc_write = dmem_ready & is_st;
        inc      = dmem_ready & is_st;
        state_nx = dmem_ready ? (is_st ? FETCH : WB) : timeout ? TRAP : MEM;
        cause_nx = (!dmem_ready && timeout) ? 2'd3 : trap_cause;
      end
      WB: begin
        regfile_write = |ins[11:7];
        wb_sel        = is_ld ? 2'd1 : (is_jal | is_jalr) ? 2'd2 : 2'd0;
        pc_write      = 1'b1;
        pc_sel        = is_jal ? 2'd1 : is_jalr ? 2'd2 : 2'd0;
        inc           = 1'b1;
        state_nx      = FETCH;
      end
      TRAP: state_nx = TRAP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      trap_cause <= 2'd0;
      instret    <= 32'd0;
    end else begin
      state      <= state_nx;
      cnt        <= (state_nx == state && (state == FETCH || state == MEM)) ? cnt + 1'b1 : '0;
      trap_cause <= cause_nx;
      instret    <= instret + {31'd0, inc};
    end
  end
endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: table-driven instruction vectors with a per-cycle output scoreboard, plus reset/trap/timeout sequences
module tb_core_ctrl;
  typedef logic [24:0] out_t;
  typedef struct { out_t exp; out_t msk; string tag; } sb_t;
  typedef struct {
    logic [31:0] ins;
    logic        eq, lt, ltu;
    int          fdly, mdly;
    logic [1:0]  kind;
    logic [1:0]  pcs;
    logic        rfw;
    logic [1:0]  wbs;
    logic        sa, sb;
    logic [9:0]  fn;
    logic [11:0] amask;
  } vec_t;
  localparam logic [1:0] K_ALU = 2'd0, K_BR = 2'd1, K_LD = 2'd2, K_ST = 2'd3;
  localparam out_t FULL = '1;
  localparam out_t NOALU = {10'h3FF, 12'h000, 3'b111};
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] ins = '0;
  logic imem_ready = 1'b0, dmem_ready = 1'b0, br_eq = 1'b0, br_lt = 1'b0, br_ltu = 1'b0;
  logic imem_req, ir_write, dmem_req, dmem_we, pc_write, regfile_write, alu_src_a, alu_src_b, halted;
  logic [1:0] pc_sel, wb_sel, trap_cause;
  logic [9:0] alu_fn;
  logic [31:0] instret;
  logic t_rst_n = 1'b0;
  logic [31:0] t_ins = '0;
  logic t_imem_ready = 1'b0, t_dmem_ready = 1'b0;
  logic t_imem_req, t_ir_write, t_dmem_req, t_dmem_we, t_pc_write, t_regfile_write, t_alu_src_a, t_alu_src_b, t_halted;
  logic [1:0] t_pc_sel, t_wb_sel, t_trap_cause;
  logic [9:0] t_alu_fn;
  logic [31:0] t_instret;
  out_t act;
  sb_t sb_q[$];
  vec_t vt[16];
  int checks = 0, errors = 0;
  logic [31:0] exp_instret = 0;
  always #5 clk = ~clk;
  core_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .ins(ins), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu), .imem_req(imem_req), .ir_write(ir_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .pc_write(pc_write), .pc_sel(pc_sel),
    .regfile_write(regfile_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_fn(alu_fn), .halted(halted), .trap_cause(trap_cause), .instret(instret)
  );
  core_ctrl #(.MEM_TIMEOUT(8), .CNT_W(8)) u_tmo (
    .clk(clk), .rst_n(t_rst_n), .ins(t_ins), .imem_ready(t_imem_ready), .dmem_ready(t_dmem_ready),
    .br_eq(1'b0), .br_lt(1'b0), .br_ltu(1'b0), .imem_req(t_imem_req), .ir_write(t_ir_write),
    .dmem_req(t_dmem_req), .dmem_we(t_dmem_we), .pc_write(t_pc_write), .pc_sel(t_pc_sel),
    .regfile_write(t_regfile_write), .wb_sel(t_wb_sel), .alu_src_a(t_alu_src_a), .alu_src_b(t_alu_src_b),
    .alu_fn(t_alu_fn), .halted(t_halted), .trap_cause(t_trap_cause), .instret(t_instret)
  );
  always_comb act = {imem_req, ir_write, dmem_req, dmem_we, pc_write, pc_sel, regfile_write,
                     wb_sel, alu_src_a, alu_src_b, alu_fn, halted, trap_cause};
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      checks++;
      if ((act & e.msk) !== (e.exp & e.msk)) begin
        errors++;
        $display("FAIL %s: got %h want %h (mask %h) at %0t", e.tag, act, e.exp, e.msk, $time);
      end
    end
  end
  function automatic out_t st(input logic imr, irw, dr, dw, pw, input logic [1:0] ps,
                              input logic rw, input logic [1:0] ws);
    return {imr, irw, dr, dw, pw, ps, rw, ws, 15'd0};
  endfunction
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", n, got, want, $time);
    end
  endtask
  task automatic step(input logic ir, input logic dr, input out_t e, input out_t m, input string tag);
    imem_ready = ir;
    dmem_ready = dr;
    sb_q.push_back('{exp: e, msk: m, tag: tag});
    @(posedge clk);
    #1;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_insn(input vec_t v, input int idx);
    out_t aluv, am;
    string s;
    s = $sformatf("v%0d", idx);
    aluv = {10'd0, v.sa, v.sb, v.fn, 3'd0};
    am = {10'h3FF, v.amask, 3'b111};
    ins = v.ins;
    br_eq = v.eq;
    br_lt = v.lt;
    br_ltu = v.ltu;
    for (int i = 0; i < v.fdly; i++) step(1'b0, 1'b1, st(1, 0, 0, 0, 0, 0, 0, 0), FULL, {s, "_fetch_wait"});
    step(1'b1, 1'b0, st(1, 1, 0, 0, 0, 0, 0, 0), FULL, {s, "_fetch"});
    step(1'b1, 1'b1, '0, FULL, {s, "_decode"});
    step(1'b1, 1'b1, aluv | ((v.kind == K_BR) ? st(0, 0, 0, 0, 1, v.pcs, 0, 0) : '0), am, {s, "_exec"});
    if (v.kind == K_LD || v.kind == K_ST) begin
      for (int i = 0; i < v.mdly; i++)
        step(1'b1, 1'b0, st(0, 0, 1, v.kind == K_ST, 0, 0, 0, 0), NOALU, {s, "_mem_wait"});
      step(1'b0, 1'b1, st(0, 0, 1, v.kind == K_ST, v.kind == K_ST, 0, 0, 0), NOALU, {s, "_mem"});
    end
    if (v.kind == K_ALU || v.kind == K_LD)
      step(1'b1, 1'b1, st(0, 0, 0, 0, 1, v.pcs, v.rfw, v.wbs), NOALU, {s, "_wb"});
    exp_instret++;
    chk({s, "_instret"}, instret, exp_instret);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vt[0]  = '{32'h002081B3, 0, 0, 0, 0, 0, K_ALU, 2'd0, 1, 2'd0, 0, 0, 10'h000, 12'hFFF};
    vt[1]  = '{32'h00208463, 1, 0, 0, 1, 0, K_BR,  2'd1, 0, 2'd0, 0, 0, 10'h000, 12'h400};
    vt[2]  = '{32'h00208463, 0, 1, 1, 0, 0, K_BR,  2'd0, 0, 2'd0, 0, 0, 10'h000, 12'h400};
    vt[3]  = '{32'h00209463, 0, 0, 0, 0, 0, K_BR,  2'd1, 0, 2'd0, 0, 0, 10'h000, 12'h400};
    vt[4]  = '{32'h0020C463, 0, 1, 0, 0, 0, K_BR,  2'd1, 0, 2'd0, 0, 0, 10'h000, 12'h400};
    vt[5]  = '{32'h0020F463, 0, 0, 1, 0, 0, K_BR,  2'd0, 0, 2'd0, 0, 0, 10'h000, 12'h400};
    vt[6]  = '{32'h0000A183, 0, 0, 0, 2, 3, K_LD,  2'd0, 1, 2'd1, 0, 1, 10'h000, 12'hFFF};
    vt[7]  = '{32'h0030A023, 0, 0, 0, 0, 1, K_ST,  2'd0, 0, 2'd0, 0, 1, 10'h000, 12'hFFF};
    vt[8]  = '{32'h000100E7, 0, 0, 0, 0, 0, K_ALU, 2'd2, 1, 2'd2, 0, 1, 10'h000, 12'hFFF};
    vt[9]  = '{32'h00010067, 0, 0, 0, 0, 0, K_ALU, 2'd2, 0, 2'd2, 0, 1, 10'h000, 12'hFFF};
    vt[10] = '{32'h4030D093, 0, 0, 0, 0, 0, K_ALU, 2'd0, 1, 2'd0, 0, 1, 10'h105, 12'hFFF};
    vt[11] = '{32'hFFF0C093, 0, 0, 0, 1, 0, K_ALU, 2'd0, 1, 2'd0, 0, 1, 10'h004, 12'hFFF};
    vt[12] = '{32'h402081B3, 0, 0, 0, 0, 0, K_ALU, 2'd0, 1, 2'd0, 0, 0, 10'h100, 12'hFFF};
    vt[13] = '{32'h123452B7, 0, 0, 0, 0, 0, K_ALU, 2'd0, 1, 2'd0, 0, 1, 10'h000, 12'hFFF};
    vt[14] = '{32'h00001297, 0, 0, 0, 0, 0, K_ALU, 2'd0, 1, 2'd0, 1, 1, 10'h000, 12'hFFF};
    vt[15] = '{32'h008000EF, 0, 0, 0, 0, 0, K_ALU, 2'd1, 1, 2'd2, 0, 0, 10'h000, 12'h000};
    repeat (2) tick();
    chk("reset_outputs", {7'd0, act}, 32'd0);
    chk("reset_instret", instret, 32'd0);
    rst_n = 1'b1;
    step(1'b1, 1'b1, '0, FULL, "idle");
    for (int i = 0; i < 16; i++) run_insn(vt[i], i);
    // asynchronous reset while a load is waiting in MEM
    ins = 32'h0000A183;
    step(1'b1, 1'b0, st(1, 1, 0, 0, 0, 0, 0, 0), FULL, "rst_fetch");
    step(1'b1, 1'b1, '0, FULL, "rst_decode");
    step(1'b1, 1'b1, '0, NOALU, "rst_exec");
    dmem_ready = 1'b0;
    #1;
    chk("rst_mem_req", {31'd0, dmem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {7'd0, act}, 32'd0);
    chk("rst_async_instret", instret, 32'd0);
    exp_instret = 0;
    tick();
    rst_n = 1'b1;
    step(1'b1, 1'b1, '0, FULL, "rst_idle");
    run_insn(vt[0], 100);
    // illegal opcode: sticky trap, strobes quiet
    ins = 32'h0000007F;
    step(1'b1, 1'b0, st(1, 1, 0, 0, 0, 0, 0, 0), FULL, "ill_fetch");
    step(1'b1, 1'b1, '0, FULL, "ill_decode");
    for (int i = 0; i < 100; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {22'd0, 1'b1, 2'd1}, FULL, "ill_trap");
    chk("ill_instret", instret, exp_instret);
    // branch with reserved funct3 traps at decode
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    step(1'b1, 1'b1, '0, FULL, "br010_idle");
    ins = 32'h0020A463;
    step(1'b1, 1'b0, st(1, 1, 0, 0, 0, 0, 0, 0), FULL, "br010_fetch");
    step(1'b1, 1'b1, '0, FULL, "br010_decode");
    step(1'b1, 1'b1, {22'd0, 1'b1, 2'd1}, FULL, "br010_trap");
    // imem timeout with MEM_TIMEOUT=8
    t_ins = 32'h0000A183;
    tick();
    t_rst_n = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("tmo_fetch_req_k%0d", k), {31'd0, t_imem_req}, 32'd1);
      chk($sformatf("tmo_fetch_halt_k%0d", k), {31'd0, t_halted}, 32'd0);
      tick();
    end
    chk("tmo_imem_halted", {31'd0, t_halted}, 32'd1);
    chk("tmo_imem_cause", {30'd0, t_trap_cause}, 32'd2);
    chk("tmo_imem_req_off", {31'd0, t_imem_req}, 32'd0);
    t_rst_n = 1'b0;
    #1;
    chk("tmo_rst_cause", {30'd0, t_trap_cause}, 32'd0);
    tick();
    t_rst_n = 1'b1;
    tick();
    for (int k = 1; k <= 7; k++) tick();
    t_imem_ready = 1'b1;
    #1;
    chk("tmo_ready_k8_irw", {31'd0, t_ir_write}, 32'd1);
    tick();
    t_imem_ready = 1'b0;
    chk("tmo_ready_k8_nohalt", {31'd0, t_halted}, 32'd0);
    tick();
    tick();
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("tmo_mem_req_k%0d", k), {31'd0, t_dmem_req}, 32'd1);
      tick();
    end
    chk("tmo_dmem_halted", {31'd0, t_halted}, 32'd1);
    chk("tmo_dmem_cause", {30'd0, t_trap_cause}, 32'd3);
    chk("tmo_dmem_instret", t_instret, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
